// File: rtl/shift_reg_seq_ctrl_pkg.sv
// shift_reg_seq_ctrl_pkg: shared state encoding and default sizes for the serial chain sequencer
package shift_reg_seq_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
endpackage

// File: rtl/shift_reg_seq_ctrl.sv
// shift_reg_seq_ctrl: shifts a parallel word MSB-first through a serial chain and checks the returned word
module shift_reg_seq_ctrl
  import shift_reg_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] tx_data,
  output logic             sr_d,
  input  logic             sr_q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             mismatch
);
  localparam int CNT_W = $clog2(WIDTH + DEPTH + 1);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_t;
  logic [WIDTH-1:0] r_shadow, r_cmp, r_cap, r_rx, w_cap_next;
  logic             r_mis, w_accept, w_last, w_tx_phase, w_rx_phase;
  assign w_accept   = (r_state == ST_IDLE) && start_valid;
  assign w_last     = r_t == CNT_W'(WIDTH + DEPTH - 1);
  assign w_tx_phase = r_t < CNT_W'(WIDTH);
  assign w_rx_phase = r_t >= CNT_W'(DEPTH);
  assign w_cap_next = WIDTH'({r_cap, sr_q});
  assign rx_data    = r_rx;
  assign mismatch   = r_mis;
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= ST_IDLE;
    else r_state <= w_next;
  // next state: accept in IDLE, leave SHIFT after the last capture, DONE lasts one cycle
  always_comb
    w_next = (r_state == ST_IDLE)  ? (start_valid ? ST_SHIFT : ST_IDLE) :
             (r_state == ST_SHIFT) ? (w_last ? ST_DONE : ST_SHIFT) : ST_IDLE;
  // outputs decoded from registers only, so sr_d has no path from any input
  always_comb begin
    start_ready = r_state == ST_IDLE;
    busy        = (r_state == ST_SHIFT) || (r_state == ST_DONE);
    done        = r_state == ST_DONE;
    sr_d        = (r_state == ST_SHIFT) && w_tx_phase && r_shadow[WIDTH-1];
  end
  // datapath: sequence counter, transmit shadow, compare copy, capture and result registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_t      <= '0;
      r_shadow <= '0;
      r_cmp    <= '0;
      r_cap    <= '0;
      r_rx     <= '0;
      r_mis    <= 1'b0;
    end else if (w_accept) begin
      r_t      <= '0;
      r_shadow <= tx_data;
      r_cmp    <= tx_data;
    end else if (r_state == ST_SHIFT) begin
      r_t <= r_t + 1'b1;
      if (w_tx_phase) r_shadow <= r_shadow << 1;
      if (w_rx_phase) r_cap <= w_cap_next;
      if (w_last) begin
        r_rx  <= w_cap_next;
        r_mis <= w_cap_next != r_cmp;
      end
    end
endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// tb_shift_reg_seq_ctrl: directed loop-back bench with a result scoreboard checked on every done pulse
module tb_shift_reg_seq_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [7:0] rx;
    logic       mis;
  } exp_t;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] tx_data = 8'h00;
  logic       sr_d;
  logic       sr_q;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       mismatch;
  logic [DEPTH-1:0] chain = '0;
  int   mode = 0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];

  shift_reg_seq_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .tx_data(tx_data), .sr_d(sr_d), .sr_q(sr_q), .busy(busy), .done(done),
    .rx_data(rx_data), .mismatch(mismatch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural DEPTH-stage chain; mode 1 inverts q, mode 2 holds q stuck at 0
  always @(posedge clk) chain <= {chain[DEPTH-2:0], sr_d};
  assign sr_q = (mode == 1) ? ~chain[DEPTH-1] : (mode == 2) ? 1'b0 : chain[DEPTH-1];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // monitor: every done pulse pops the oldest expected result
  always @(negedge clk)
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_rx_data", {24'h0, rx_data}, {24'h0, e.rx});
        check("sb_mismatch", {31'h0, mismatch}, {31'h0, e.mis});
      end
    end

  task automatic run(input logic [7:0] d, input logic [7:0] erx, input logic emis,
                     input int abort_t, input logic [7:0] d_after);
    int n;
    int done_t;
    logic [11:0] sr_seen;
    start_valid = 1'b1;
    tx_data = d;
    n = 0;
    while (!start_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {31'h0, start_ready}, 32'd1);
    if (abort_t < 0) sb.push_back('{rx: erx, mis: emis});
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    tx_data = d_after;
    done_t = -1;
    sr_seen = '0;
    for (int t = 0; t < 40 && done_t < 0; t++) begin
      @(negedge clk);
      if (t == abort_t) begin
        reset = 1'b0;
        #1;
        check("rst_start_ready", {31'h0, start_ready}, 32'd1);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_sr_d", {31'h0, sr_d}, 32'd0);
        check("rst_rx_data", {24'h0, rx_data}, 32'd0);
        check("rst_mismatch", {31'h0, mismatch}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        return;
      end
      if (t == 0) begin
        check("shift_busy", {31'h0, busy}, 32'd1);
        check("shift_ready", {31'h0, start_ready}, 32'd0);
      end
      if (t < 12) sr_seen[11-t] = sr_d;
      if (done) done_t = t;
    end
    check("done_latency", done_t, 32'd12);
    check("sr_d_sequence", {20'h0, sr_seen}, {20'h0, d, 4'h0});
  endtask

  initial begin
    int n, c1, c2;
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c1, c2;
    @(negedge clk);
    check("reset_start_ready", {31'h0, start_ready}, 32'd1);
    check("reset_busy", {31'h0, busy}, 32'd0);
    check("reset_done", {31'h0, done}, 32'd0);
    check("reset_sr_d", {31'h0, sr_d}, 32'd0);
    check("reset_rx_data", {24'h0, rx_data}, 32'd0);
    check("reset_mismatch", {31'h0, mismatch}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run(8'hA5, 8'hA5, 1'b0, -1, 8'hA5);
    mode = 1;
    run(8'hA5, 8'h5A, 1'b1, -1, 8'hA5);
    mode = 0;
    repeat (3) @(negedge clk);
    check("hold_mismatch", {31'h0, mismatch}, 32'd1);
    check("hold_rx_data", {24'h0, rx_data}, 32'h5A);
    run(8'hC3, 8'h00, 1'b0, 5, 8'hC3);
    run(8'h96, 8'h96, 1'b0, -1, 8'h96);
    mode = 2;
    run(8'hFF, 8'h00, 1'b1, -1, 8'hFF);
    mode = 0;
    run(8'h3C, 8'h3C, 1'b0, -1, 8'h3C);
    start_valid = 1'b1;
    tx_data = 8'h01;
    n = 0;
    while (!start_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    c1 = cyc;
    sb.push_back('{rx: 8'h01, mis: 1'b0});
    @(posedge clk);
    #1;
    tx_data = 8'h80;
    @(negedge clk);
    n = 0;
    while (!start_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    c2 = cyc;
    check("held_accept_gap", c2 - c1, 32'd14);
    sb.push_back('{rx: 8'h80, mis: 1'b0});
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (16) @(negedge clk);
    run(8'hF0, 8'hF0, 1'b0, -1, 8'h00);
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
